// File: rtl/seven_seg_scan_pkg.sv
// seven_seg_scan_pkg: display codes and segment patterns shared with the game FSM
package seven_seg_scan_pkg;
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_DASH = 4'd11;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  typedef struct packed {
    logic [3:0][3:0] code;
    logic [3:0] blink;
    logic [3:0] dp;
  } shadow_t;
endpackage

// File: rtl/seven_seg_scan_seg7_decode.sv
// seg7_decode: 4-bit display code to active-low {g..a} segments
module seg7_decode
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  // digits index the pattern table; dash is the only other visible code
  always_comb seg = (code < 4'd10) ? SEG_DIGITS[code] : (code == CODE_DASH) ? SEG_DASH : SEG_BLANK;
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: frame-snapshotted 4-digit multiplexed seven-segment driver with blink and dp
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [FW-1:0] fcnt;
  logic blink_phase;
  shadow_t sh;
  logic tick, wrap, off;
  logic [6:0] dec;
  assign tick = presc == PW'(SCAN_DIV - 1);
  assign frame_tick = tick && idx == 2'd3;
  assign wrap = frame_tick && fcnt == FW'(BLINK_FRAMES - 1);
  assign off = blink_phase && sh.blink[idx];
  seg7_decode u_dec (.code(sh.code[idx]), .seg(dec));
  // slot prescaler and digit index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= '0;
      idx <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      idx <= idx + 2'(tick);
    end
  // latch inputs only at the frame boundary so a frame never mixes old and new digits
  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= {{4{CODE_BLANK}}, 8'h00};
    else if (frame_tick) sh <= {dig3, dig2, dig1, dig0, blink_mask, dp_mask};
  // blink half-period counted in frames; phase flips together with the snapshot it governs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fcnt <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      fcnt <= wrap ? '0 : fcnt + 1'b1;
      blink_phase <= blink_phase ^ wrap;
    end
  // registered pin drive; anodes stay dark for the first GUARD cycles of each slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      an <= 4'b1111;
      seg <= SEG_BLANK;
      dp <= 1'b1;
    end else begin
      an <= (presc < PW'(GUARD)) ? 4'b1111 : ~(4'b0001 << idx);
      seg <= off ? SEG_BLANK : dec;
      dp <= off | ~sh.dp[idx];
    end
endmodule
